// File: rtl/mealy_pkg.sv
// Shared definitions for the 3-state Mealy code generator and its stream decoder:
// state encoding, code constants and the legal-transition table.
package mealy_pkg;

  typedef enum logic [1:0] {
    T_START = 2'd0,
    T_S1    = 2'd1,
    T_S2    = 2'd2
  } mealy_state_e;

  localparam logic [2:0] CODE_START   = 3'b100;
  localparam logic [2:0] CODE_S1_ONE  = 3'b011;
  localparam logic [2:0] CODE_S1_ZERO = 3'b001;
  localparam logic [2:0] CODE_S2_ONE  = 3'b000;
  localparam logic [2:0] CODE_S2_ZERO = 3'b010;

  typedef struct packed {
    logic         legal;
    logic         has_bit;
    logic         bit_val;
    mealy_state_e next;
  } dec_result_t;

  // Legal-code table for the receive side; illegal codes report legal = 0.
  function automatic dec_result_t decode_code(input mealy_state_e st, input logic [2:0] code);
    dec_result_t r;
    r.legal   = 1'b0;
    r.has_bit = 1'b0;
    r.bit_val = 1'b0;
    r.next    = T_START;
    unique case (st)
      T_START: begin
        if (code == CODE_START) begin
          r.legal = 1'b1;
          r.next  = T_S1;
        end
      end
      T_S1: begin
        if (code == CODE_S1_ONE) begin
          r.legal   = 1'b1;
          r.has_bit = 1'b1;
          r.bit_val = 1'b1;
          r.next    = T_S2;
        end else if (code == CODE_S1_ZERO) begin
          r.legal   = 1'b1;
          r.has_bit = 1'b1;
          r.bit_val = 1'b0;
          r.next    = T_START;
        end
      end
      T_S2: begin
        if (code == CODE_S2_ONE) begin
          r.legal   = 1'b1;
          r.has_bit = 1'b1;
          r.bit_val = 1'b1;
          r.next    = T_S2;
        end else if (code == CODE_S2_ZERO) begin
          r.legal   = 1'b1;
          r.has_bit = 1'b1;
          r.bit_val = 1'b0;
          r.next    = T_START;
        end
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mealy_word_packer.sv
// Packs recovered bits LSB-first into WORD_W-bit words and presents them through
// a single holding register with a valid/ready handshake and sticky overflow.
module mealy_word_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic              bit_i,
  input  logic              flush_i,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              ovf_o
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              ovf_q, ovf_d;
  logic              consume;
  logic [WORD_W-1:0] full_word;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ovf_d        = ovf_q;
    consume      = hold_valid_q && word_ready_i;
    full_word    = shift_q;
    full_word[bit_cnt_q] = bit_i;

    if (consume) begin
      hold_valid_d = 1'b0;
    end

    if (flush_i) begin
      bit_cnt_d = '0;
    end else if (push_i) begin
      shift_d = full_word;
      if (bit_cnt_q == LAST_IDX) begin
        bit_cnt_d = '0;
        // A consume in this same cycle frees the holding register for the new word.
        if (!hold_valid_q || consume) begin
          hold_d       = full_word;
          hold_valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign word_o       = hold_q;
  assign word_valid_o = hold_valid_q;
  assign ovf_o        = ovf_q;

endmodule

// File: rtl/mealy_stream_decoder.sv
// Tracks the Mealy generator state from its output codes, recovers the input bits
// and flags illegal codes. Define MEALY_DEC_ERRCNT_EN to build the saturating error counter.
module mealy_stream_decoder
  import mealy_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic [2:0]          code_i,
  output logic                bit_o,
  output logic                bit_valid_o,
  output logic [WORD_W-1:0]   word_o,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic                err_o,
  output logic                ovf_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  mealy_state_e state_q, state_d;
  logic         bit_q, bit_d;
  logic         bit_valid_q, bit_valid_d;
  logic         err_q, err_d;
  logic         push;
  logic         flush;
  dec_result_t  dec;

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    err_d       = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    dec         = decode_code(state_q, code_i);

    if (valid_i) begin
      if (dec.legal) begin
        state_d = dec.next;
        if (dec.has_bit) begin
          push        = 1'b1;
          bit_d       = dec.bit_val;
          bit_valid_d = 1'b1;
        end
      end else begin
        // An illegal start code still marks a frame start, so resync into T_S1.
        err_d   = 1'b1;
        flush   = 1'b1;
        state_d = (code_i == CODE_START) ? T_S1 : T_START;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= T_START;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      err_q       <= err_d;
    end
  end

  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign err_o       = err_q;

`ifdef MEALY_DEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  mealy_word_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .bit_i        (bit_d),
    .flush_i      (flush),
    .word_ready_i (word_ready_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .ovf_o        (ovf_o)
  );

endmodule

// File: tb/tb_mealy_stream_decoder.sv
// Self-checking bench for mealy_stream_decoder (WORD_W=4): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mealy_stream_decoder;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [2:0]    code_i;
  logic          word_ready_i;
  logic          bit_o, bit_valid_o, word_valid_o, err_o, ovf_o;
  logic [W-1:0]  word_o;
  logic [CW-1:0] err_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state (states: 0 = idle/start, 1 = after start code, 2 = after a 1)
  int           m_state;
  logic         m_bits[$];
  logic [W-1:0] m_word;
  logic         m_wv, m_ovf, m_bv, m_b, m_err;
  int unsigned  m_cnt;

  mealy_stream_decoder #(
    .WORD_W   (W),
    .ERRCNT_W (CW)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .code_i       (code_i),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid_o),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .err_o        (err_o),
    .ovf_o        (ovf_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int unsigned exp_cnt(input int unsigned n);
`ifdef MEALY_DEC_ERRCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic void ref_decode(input int st, input logic [2:0] c, output bit legal,
                                     output bit has_bit, output bit b, output int nxt);
    legal = 0; has_bit = 0; b = 0; nxt = 0;
    if (st == 0 && c == 3'b100) begin legal = 1; nxt = 1; end
    else if (st == 1 && c == 3'b011) begin legal = 1; has_bit = 1; b = 1; nxt = 2; end
    else if (st == 1 && c == 3'b001) begin legal = 1; has_bit = 1; b = 0; nxt = 0; end
    else if (st == 2 && c == 3'b000) begin legal = 1; has_bit = 1; b = 1; nxt = 2; end
    else if (st == 2 && c == 3'b010) begin legal = 1; has_bit = 1; b = 0; nxt = 0; end
  endfunction

  task automatic model_reset();
    m_state = 0; m_bits.delete(); m_word = '0; m_wv = 0; m_ovf = 0;
    m_bv = 0; m_b = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] c, input logic rdy);
    bit legal, has_bit, b;
    int nxt;
    logic busy;
    logic [W-1:0] w;
    busy  = m_wv && !rdy;
    m_bv  = 0;
    m_err = 0;
    if (m_wv && rdy) m_wv = 0;
    if (v) begin
      ref_decode(m_state, c, legal, has_bit, b, nxt);
      if (!legal) begin
        m_err = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_bits.delete();
        m_state = (c == 3'b100) ? 1 : 0;
      end else begin
        m_state = nxt;
        if (has_bit) begin
          m_bv = 1;
          m_b  = b;
          m_bits.push_back(b);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) w[i] = m_bits[i];
            m_bits.delete();
            if (busy) m_ovf = 1;
            else begin m_word = w; m_wv = 1; end
          end
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic rdy);
    @(negedge clk_i);
    valid_i = v; code_i = c; word_ready_i = rdy;
    @(posedge clk_i);
    model_edge(v, c, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1; valid_i = 0; code_i = '0; word_ready_i = 0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    reset_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    reset_i = 1;
    #1;
    checks++;
    if ({bit_o, bit_valid_o, word_valid_o, err_o, ovf_o} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {bit_o, bit_valid_o, word_valid_o, err_o, ovf_o});
    end
    checks++;
    if (word_o !== '0) begin failures++; $display("FAIL reset_word got=%h exp=0", word_o); end
    checks++;
    if (err_cnt_o !== '0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt_o); end
    @(negedge clk_i);
    reset_i = 0;
  endtask

  task automatic test_basic_decode();
    logic [2:0] codes [6] = '{3'b100, 3'b011, 3'b000, 3'b010, 3'b100, 3'b001};
    logic [7:0] got = '0;
    int npulse = 0, nerr = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, codes[i], 1);
      if (bit_valid_o) begin
        if (npulse < 8) got[npulse] = bit_o;
        npulse++;
      end
      if (err_o) nerr++;
    end
    checks++;
    if (npulse != 4) begin failures++; $display("FAIL basic_pulses got=%0d exp=4", npulse); end
    checks++;
    if (got[3:0] !== 4'b0011) begin failures++; $display("FAIL basic_bits got=%b exp=0011", got[3:0]); end
    checks++;
    if (nerr != 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", nerr); end
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h3) begin
      failures++; $display("FAIL basic_word got=%b/%h exp=1/3", word_valid_o, word_o);
    end
    step(0, 3'b000, 1);
    checks++;
    if (word_valid_o !== 1'b0) begin failures++; $display("FAIL basic_consume got=%b exp=0", word_valid_o); end
  endtask

  task automatic test_illegal_from_reset();
    do_reset();
    step(1, 3'b011, 1);
    checks++;
    if (err_o !== 1'b1 || bit_valid_o !== 1'b0) begin
      failures++; $display("FAIL illegal_err got=%b/%b exp=1/0", err_o, bit_valid_o);
    end
    checks++;
    if (err_cnt_o !== CW'(exp_cnt(1))) begin
      failures++; $display("FAIL illegal_cnt got=%0d exp=%0d", err_cnt_o, exp_cnt(1));
    end
    step(1, 3'b100, 1);
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL illegal_resync got=%b exp=0", err_o); end
    step(1, 3'b001, 1);
    checks++;
    if (bit_valid_o !== 1'b1 || bit_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL illegal_next_bit got=%b/%b/%b exp=1/0/0", bit_valid_o, bit_o, err_o);
    end
  endtask

  task automatic test_resync_s2();
    do_reset();
    step(1, 3'b100, 1); step(1, 3'b011, 1); step(1, 3'b000, 1);
    step(1, 3'b100, 1);
    checks++;
    if (err_o !== 1'b1) begin failures++; $display("FAIL resync_err got=%b exp=1", err_o); end
    step(1, 3'b011, 1);
    checks++;
    if (err_o !== 1'b0 || bit_valid_o !== 1'b1 || bit_o !== 1'b1) begin
      failures++; $display("FAIL resync_s1 got=%b/%b/%b exp=0/1/1", err_o, bit_valid_o, bit_o);
    end
    step(1, 3'b000, 1);
    checks++;
    if (word_valid_o !== 1'b0) begin failures++; $display("FAIL resync_partial got=%b exp=0", word_valid_o); end
    step(1, 3'b010, 1); step(1, 3'b100, 1); step(1, 3'b001, 1);
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h3) begin
      failures++; $display("FAIL resync_word got=%b/%h exp=1/3", word_valid_o, word_o);
    end
  endtask

  task automatic send_word3(input logic rdy);
    step(1, 3'b100, rdy); step(1, 3'b011, rdy); step(1, 3'b000, rdy);
    step(1, 3'b010, rdy); step(1, 3'b100, rdy); step(1, 3'b001, rdy);
  endtask

  task automatic test_overflow();
    do_reset();
    send_word3(0);
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h3 || ovf_o !== 1'b0) begin
      failures++; $display("FAIL ovf_first got=%b/%h/%b exp=1/3/0", word_valid_o, word_o, ovf_o);
    end
    step(1, 3'b100, 0); step(1, 3'b011, 0); step(1, 3'b000, 0); step(1, 3'b000, 0);
    checks++;
    if (word_o !== 4'h3 || ovf_o !== 1'b0) begin
      failures++; $display("FAIL ovf_hold got=%h/%b exp=3/0", word_o, ovf_o);
    end
    step(1, 3'b000, 0);
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h3 || ovf_o !== 1'b1) begin
      failures++; $display("FAIL ovf_drop got=%b/%h/%b exp=1/3/1", word_valid_o, word_o, ovf_o);
    end
    step(0, 3'b000, 1);
    checks++;
    if (word_valid_o !== 1'b0 || ovf_o !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b/%b exp=0/1", word_valid_o, ovf_o);
    end
    step(1, 3'b010, 0); step(1, 3'b100, 0); step(1, 3'b011, 0); step(1, 3'b000, 0); step(1, 3'b010, 0);
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h6) begin
      failures++; $display("FAIL ovf_wrap got=%b/%h exp=1/6", word_valid_o, word_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word3(0);
    step(1, 3'b100, 0); step(1, 3'b011, 0); step(1, 3'b000, 0); step(1, 3'b000, 0);
    step(1, 3'b000, 1);
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'hF || ovf_o !== 1'b0) begin
      failures++; $display("FAIL b2b_load got=%b/%h/%b exp=1/f/0", word_valid_o, word_o, ovf_o);
    end
    step(0, 3'b000, 1);
    checks++;
    if (word_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_consume got=%b exp=0", word_valid_o); end
  endtask

  task automatic test_gaps_and_reset();
    int bad = 0;
    do_reset();
    step(1, 3'b110, 0);
    checks++;
    if (err_o !== 1'b1 || err_cnt_o !== CW'(exp_cnt(1))) begin
      failures++; $display("FAIL gap_err got=%b/%0d exp=1/%0d", err_o, err_cnt_o, exp_cnt(1));
    end
    step(1, 3'b100, 0);
    step(0, 3'b011, 0); if (bit_valid_o || err_o) bad++;
    step(0, 3'b111, 0); if (bit_valid_o || err_o) bad++;
    step(1, 3'b011, 0);
    step(0, 3'b010, 0); if (bit_valid_o || err_o) bad++;
    step(1, 3'b000, 0); step(1, 3'b000, 0); step(1, 3'b010, 0);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL gap_hold got=%0d exp=0", bad); end
    checks++;
    if (word_valid_o !== 1'b1 || word_o !== 4'h7) begin
      failures++; $display("FAIL gap_word got=%b/%h exp=1/7", word_valid_o, word_o);
    end
    @(negedge clk_i);
    #2 reset_i = 1;
    #1;
    checks++;
    if ({bit_o, bit_valid_o, word_valid_o, err_o, ovf_o} !== 5'b0 || word_o !== '0 || err_cnt_o !== '0) begin
      failures++; $display("FAIL gap_async_reset got=%b/%h/%0d exp=00000/0/0",
                           {bit_o, bit_valid_o, word_valid_o, err_o, ovf_o}, word_o, err_cnt_o);
    end
    @(negedge clk_i);
    reset_i = 0;
    model_reset();
    step(1, 3'b100, 0);
    checks++;
    if (err_o !== 1'b0 || err_cnt_o !== '0) begin
      failures++; $display("FAIL gap_after_reset got=%b/%0d exp=0/0", err_o, err_cnt_o);
    end
  endtask

  task automatic test_err_saturation();
    do_reset();
    for (int i = 0; i < 255; i++) step(1, 3'b111, 0);
    checks++;
    if (err_cnt_o !== CW'(exp_cnt(255))) begin
      failures++; $display("FAIL sat_reach got=%0d exp=%0d", err_cnt_o, exp_cnt(255));
    end
    for (int i = 0; i < 5; i++) step(1, 3'b111, 0);
    checks++;
    if (err_cnt_o !== CW'(exp_cnt(255)) || err_o !== 1'b1) begin
      failures++; $display("FAIL sat_hold got=%0d/%b exp=%0d/1", err_cnt_o, err_o, exp_cnt(255));
    end
  endtask

  task automatic test_random();
    logic v, r;
    logic [2:0] c;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) < 8) begin
        case (m_state)
          0:       c = 3'b100;
          1:       c = $urandom_range(0, 1) ? 3'b011 : 3'b001;
          default: c = $urandom_range(0, 1) ? 3'b000 : 3'b010;
        endcase
      end else begin
        c = 3'($urandom_range(0, 7));
      end
      step(v, c, r);
      checks++;
      if (bit_valid_o !== m_bv || (m_bv && bit_o !== m_b)) begin
        failures++; $display("FAIL rand_bit cyc=%0d got=%b/%b exp=%b/%b", cyc, bit_valid_o, bit_o, m_bv, m_b);
      end
      checks++;
      if (err_o !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err_o, m_err); end
      checks++;
      if (word_valid_o !== m_wv || (m_wv && word_o !== m_word)) begin
        failures++; $display("FAIL rand_word cyc=%0d got=%b/%h exp=%b/%h", cyc, word_valid_o, word_o, m_wv, m_word);
      end
      checks++;
      if (ovf_o !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, ovf_o, m_ovf); end
      checks++;
      if (err_cnt_o !== CW'(exp_cnt(m_cnt))) begin
        failures++; $display("FAIL rand_errcnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt_o, exp_cnt(m_cnt));
      end
    end
  endtask

  initial begin
    reset_i = 1; valid_i = 0; code_i = '0; word_ready_i = 0;
    model_reset();
    test_reset();
    test_basic_decode();
    test_illegal_from_reset();
    test_resync_s2();
    test_overflow();
    test_back_to_back();
    test_gaps_and_reset();
    test_err_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mealy_stream_decoder.md
Name: mealy_stream_decoder

Overview:
- Receive-side companion to the 3-state Mealy code generator. Consumes its per-cycle 3-bit output codes, tracks the generator state and recovers the original input bit stream.
- Packs recovered bits into WORD_W-bit words with a valid/ready output handshake.
- Flags protocol violations: codes that are illegal for the tracked state.

Parameters:
- WORD_W, 8, width of assembled output word (>=2)
- ERRCNT_W, 8, width of saturating error counter

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- valid_i  in  1  code_i is valid this cycle
- code_i  in  3  generator output code
- bit_o  out  1  recovered input bit
- bit_valid_o  out  1  one-cycle pulse, bit_o valid
- word_o  out  WORD_W  assembled word, LSB = first bit received
- word_valid_o  out  1  word_o holds an unconsumed word
- word_ready_i  in  1  consumer accepts word_o
- err_o  out  1  one-cycle pulse, illegal code
- ovf_o  out  1  sticky, word dropped because the holding register was full
- err_cnt_o  out  ERRCNT_W  saturating illegal-code count (see Optional Feature)

Behaviour:
- Reset: tracker = T_START, bit_cnt = 0, shift register = 0. All outputs 0.
- Codes are consumed only when valid_i = 1. With valid_i = 0, tracker and assembler hold.
- Tracker states and legal codes (any other code is illegal):
  - T_START: only 100 is legal -> T_S1, no bit emitted.
  - T_S1: 011 -> bit 1, go to T_S2. 001 -> bit 0, go to T_START.
  - T_S2: 000 -> bit 1, stay in T_S2. 010 -> bit 0, go to T_START.
- Illegal code handling:
  - err_o pulses next cycle and err_cnt_o increments, saturating at all-ones.
  - Partial word is discarded (bit_cnt = 0).
  - Resync: if the illegal code is 100, go to T_S1; otherwise go to T_START.
- Latency: a code accepted in cycle N drives bit_o/bit_valid_o and err_o in cycle N+1. All outputs are registered.
- Assembler:
  - Each recovered bit is written at position bit_cnt, then bit_cnt increments.
  - On the WORD_W-th bit, the full word transfers to the holding register and bit_cnt wraps to 0.
  - word_valid_o goes high in the same cycle as that bit's bit_valid_o.
- Holding register handshake:
  - Word is consumed when word_valid_o && word_ready_i.
  - word_o stays stable while word_valid_o = 1 and not consumed.
- Boundary cases:
  - Word completes while the holding register is full and not being consumed: the new word is dropped, ovf_o is set, and bit_cnt still wraps.
  - Word completes in the same cycle as a consume: the new word loads and word_valid_o stays 1. No overflow.
  - ovf_o clears only on reset.
- Word assembly spans frame boundaries; a return to T_START does not flush bits.
- Reset mid-operation: everything clears immediately, including any pending word.

Optional Feature:
- Macro: MEALY_DEC_ERRCNT_EN.
- Defined: err_cnt_o is a live ERRCNT_W-bit saturating counter.
- Undefined: the counter register is not built and err_cnt_o is tied to 0. err_o is unaffected.

Decomposition:
- Shared package mealy_pkg:
  - 2-bit state typedef, encoding START=0, S1=1, S2=2, shared with the generator.
  - Code constants: CODE_START=3'b100, CODE_S1_ONE=3'b011, CODE_S1_ZERO=3'b001, CODE_S2_ONE=3'b000, CODE_S2_ZERO=3'b010.
- Sub-module mealy_word_packer: bit_cnt, shift register, holding register, valid/ready handshake and overflow. The top level holds the tracker FSM and error logic.

Test Plan:
- WORD_W=4, codes 100,011,000,010,100,001, ready=1 -> bits 1,1,0,0 over 4 pulses; word_o=4'h3, word_valid_o pulse; err_o never 1.
- From reset, code 011 -> err_o=1 next cycle, err_cnt_o=1, tracker T_START; then 100,001 decodes bit 0 normally.
- In T_S2, code 100 -> err_o=1, tracker T_S1, partial bit_cnt=2 cleared; following 011 is treated as bit 0 of a new word.
- ready=0, send 8 bits (WORD_W=4) -> first word held unchanged, second word dropped, ovf_o=1 after the eighth bit.
- ready pulses in the same cycle the next word completes -> word_valid_o stays 1, new value loaded, ovf_o=0.
- valid_i toggled between codes plus reset_i asserted mid-word -> holds during gaps; reset clears all outputs, including err_cnt_o=0 (macro defined) and err_cnt_o constant 0 (macro undefined).
